// File: rtl/ifu.sv
// rtl/ifu.sv - instruction fetch unit: single-outstanding AXI-lite read master feeding IDU
module ifu #(
    parameter int unsigned          ADDR_W   = 32,
    parameter int unsigned          DATA_W   = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC = 32'h8000_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [ADDR_W-1:0]   araddr,
    output logic                arvalid,
    input  logic                arready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rvalid,
    output logic                rready,
    output logic                awvalid,
    output logic [ADDR_W-1:0]   awaddr,
    output logic                wvalid,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                bready,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_inst,
    output logic [ADDR_W-1:0]   out_pc,
    output logic                out_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_HOLD
    } state_t;

    state_t              state, state_d;
    logic [ADDR_W-1:0]   pc, pc_d;
    logic [DATA_W-1:0]   inst_q, inst_d;
    logic                err_q, err_d;
    logic                drop, drop_d;
    logic                pend_valid, pend_valid_d;
    logic [ADDR_W-1:0]   pend_pc, pend_pc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            inst_q     <= '0;
            err_q      <= 1'b0;
            drop       <= 1'b0;
            pend_valid <= 1'b0;
            pend_pc    <= '0;
        end else begin
            pc         <= pc_d;
            inst_q     <= inst_d;
            err_q      <= err_d;
            drop       <= drop_d;
            pend_valid <= pend_valid_d;
            pend_pc    <= pend_pc_d;
        end
    end

    always_comb begin
        state_d      = state;
        pc_d         = pc;
        inst_d       = inst_q;
        err_d        = err_q;
        drop_d       = drop;
        pend_valid_d = pend_valid;
        pend_pc_d    = pend_pc;
        case (state)
            S_IDLE: begin
                state_d = S_AR;
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end
            end
            S_AR: begin
                // araddr must stay put until accepted, so a redirect is parked
                if (redirect_valid) begin
                    drop_d       = 1'b1;
                    pend_valid_d = 1'b1;
                    pend_pc_d    = redirect_pc;
                end
                if (arready) begin
                    state_d = S_R;
                end
            end
            S_R: begin
                if (rvalid) begin
                    if (drop || redirect_valid) begin
                        if (redirect_valid) begin
                            pc_d = redirect_pc;
                        end else if (pend_valid) begin
                            pc_d = pend_pc;
                        end
                        drop_d       = 1'b0;
                        pend_valid_d = 1'b0;
                        state_d      = S_AR;
                    end else begin
                        inst_d  = rdata;
                        err_d   = (rresp != 2'b00);
                        state_d = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    drop_d       = 1'b1;
                    pend_valid_d = 1'b1;
                    pend_pc_d    = redirect_pc;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = S_AR;
                end else if (out_ready) begin
                    pc_d    = pc + ADDR_W'(4);
                    state_d = S_AR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // pc holds RESET_PC during reset; gate the address outputs so they read 0
    assign araddr    = rst_n ? pc : '0;
    assign out_pc    = rst_n ? pc : '0;
    assign arvalid   = (state == S_AR);
    assign rready    = (state == S_R);
    assign out_valid = (state == S_HOLD) && !redirect_valid;
    assign out_inst  = inst_q;
    assign out_err   = err_q;

    assign awvalid = 1'b0;
    assign awaddr  = '0;
    assign wvalid  = 1'b0;
    assign wdata   = '0;
    assign wstrb   = '0;
    assign bready  = 1'b0;

endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit: AXI-lite read master sitting directly upstream of the instruction SRAM slave and feeding the decode stage. Holds the PC, issues one AR request at a time, and captures the R response. Presents the fetched instruction to IDU over a valid/ready handshake. Accepts control-flow redirects from later stages and discards wrong-path responses.

## Interface
- ADDR_W, 32, AXI address / PC width
- DATA_W, 32, AXI data / instruction width
- RESET_PC, 32'h8000_0000, first fetch address after reset
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- araddr  out  ADDR_W  read address (current PC)
- arvalid  out  1  read address valid
- arready  in  1  slave accepts address
- rdata  in  DATA_W  read data
- rresp  in  2  read response; 2'b00 = OKAY
- rvalid  in  1  read data valid
- rready  out  1  master accepts read data
- awvalid, wvalid, bready  out  1 each  tied 0 (block is read-only); awaddr/wdata/wstrb tied 0
- redirect_valid  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  ADDR_W  new fetch address
- out_valid  out  1  instruction valid to IDU
- out_ready  in  1  IDU accepts instruction
- out_inst  out  DATA_W  fetched instruction
- out_pc  out  ADDR_W  address of out_inst
- out_err  out  1  rresp was not OKAY for this instruction

## Operation
- State register: IDLE, AR, R, HOLD. Additional registers: pc, inst_q, err_q, drop (1 bit), pend_valid/pend_pc (redirect captured during AR).
- Reset (async, any time, including mid-transaction): state=IDLE, pc=RESET_PC, drop=0, pend_valid=0, inst_q=0, err_q=0. All outputs 0 while rst_n=0.
- Outputs decode from state: arvalid=(state==AR), araddr=pc, rready=(state==R), out_valid=(state==HOLD)&&!redirect_valid, out_inst=inst_q, out_pc=pc, out_err=err_q.
- IDLE -> AR unconditionally on the first edge after reset release.
- AR: stay until arvalid&&arready, then -> R. araddr and arvalid are held stable until accepted (AXI rule). redirect_valid in AR does not change araddr: set drop=1, pend_valid=1, pend_pc=redirect_pc.
- R: on rvalid&&rready:
  - drop=0 and no redirect this cycle: inst_q=rdata, err_q=(rresp!=0), -> HOLD.
  - drop=1 or redirect_valid: discard rdata; pc=redirect_pc if redirect_valid this cycle, else pend_pc; clear drop and pend_valid; -> AR.
- R without response: redirect_valid sets drop=1, pend_pc=redirect_pc. The latest redirect wins.
- HOLD: out_valid&&out_ready -> pc=pc+4 (mod 2^ADDR_W, wraps silently), -> AR. redirect_valid has priority over out_ready: pc=redirect_pc, -> AR, instruction discarded, no handoff.
- IDLE with redirect_valid: pc=redirect_pc, -> AR.
- At most one outstanding read. No speculation beyond pc+4.
- Error response is not retried. The instruction is forwarded with out_err=1 and IDU raises the fault.

## Timing
- Edge 0 = first edge with rst_n=1: IDLE->AR. arvalid=1, araddr=RESET_PC in cycle 1.
- AR accepted at edge t -> rready=1 from cycle t+1. Data captured on the rvalid&&rready edge u -> out_valid=1 from cycle u+1.
- Handoff at edge h -> arvalid=1 with pc+4 in cycle h+1. Minimum cycles per instruction = 3 + slave AR wait + slave read latency.
- out_inst/out_pc are stable while out_valid=1 and out_ready=0.
- redirect_valid -> out_valid is a combinational path (same-cycle suppression). All other outputs are registered-state decodes.
- Redirect latency: new PC appears on araddr the cycle after the redirect edge (IDLE/HOLD), or the cycle after the in-flight response completes (AR/R).

## Test plan
- Reset then slave with arready=1 in idle, 2-cycle read latency, memory[0x80000000]=0x00000413: araddr=0x80000000 in cycle 1; out_valid with out_inst=0x00000413, out_pc=0x80000000; next araddr=0x80000004 the cycle after the handoff.
- IDU backpressure: out_ready=0 for 5 cycles -> out_valid/out_inst/out_pc held constant, arvalid=0 throughout. out_ready=1 -> single handoff, then AR to pc+4.
- Redirect during R (redirect_pc=0x80000100): response for 0x80000004 discarded (out_valid never 1 for it); next araddr=0x80000100. Two redirects in R (0x100, then 0x200) -> fetch 0x80000200.
- Redirect in HOLD with out_ready=1 in the same cycle: out_valid=0 that cycle, no handoff, next araddr=redirect_pc.
- rresp=2'b10 on fetch of 0x80000008 -> out_err=1 with out_pc=0x80000008. Next fetch 0x8000000C returns with out_err=0.
- Async reset asserted while state=R, mid-latency -> all outputs 0 immediately. After release, fetch restarts at 0x80000000, stale rvalid ignored (rready=0).
